// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes an address-derived pattern over a range, reads it back
// in order and reports pass/fail, error count, first failing address and timeout.
module mem_bist_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 24,
    parameter logic [31:0] PATTERN = 32'h00FFFFFF,
    parameter int unsigned MAX_OUT = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned ERR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              wr_rdy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rd_rdy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] rd_cnt
);

    localparam int unsigned OUT_W = $clog2(MAX_OUT) + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [OUT_W-1:0] MaxOut  = OUT_W'(MAX_OUT);
    localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q, num_q, wr_idx_q, rd_idx_q, chk_idx_q;
    logic [1:0]        mode_q;
    logic [OUT_W-1:0]  out_q, out_d;
    logic [TMO_W-1:0]  tmo_q;
    logic              rd_acc, live, rd_ret, spurious, mismatch, tmo_hit;

    function automatic logic [DATA_W-1:0] pattern_f(input logic [1:0] mode,
                                                    input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] sh;
        logic [DATA_W-1:0] res;
        sh = a % ADDR_W'(DATA_W);
        case (mode)
            2'd0:    res = DATA_W'(PATTERN);
            2'd1:    res = DATA_W'(a);
            2'd2:    res = DATA_W'(1) << sh;
            default: res = ~DATA_W'(a);
        endcase
        return res;
    endfunction

    // A return only counts when a read is actually in flight; anything else is spurious.
    always_comb begin
        rd_acc   = rd_en && rd_rdy;
        live     = ((state_q == StRead) || (state_q == StDrain)) && (out_q != '0);
        rd_ret   = rd_data_valid && live;
        spurious = rd_data_valid && !live;
        out_d    = out_q + OUT_W'(rd_acc) - OUT_W'(rd_ret);
        mismatch = rd_ret && (rd_data != pattern_f(mode_q, chk_idx_q));
        tmo_hit  = live && !rd_data_valid && (tmo_q == TmoLast);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            base_q         <= '0;
            num_q          <= '0;
            mode_q         <= '0;
            wr_idx_q       <= '0;
            rd_idx_q       <= '0;
            chk_idx_q      <= '0;
            out_q          <= '0;
            tmo_q          <= '0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            rd_en          <= 1'b0;
            rd_addr        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            rd_cnt         <= '0;
        end else begin
            out_q <= out_d;
            if (rd_ret) begin
                chk_idx_q <= chk_idx_q + ADDR_W'(1);
                rd_cnt    <= rd_cnt + ADDR_W'(1);
                tmo_q     <= '0;
                if (mismatch) begin
                    fail <= 1'b1;
                    if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                    if (err_cnt == '0) first_err_addr <= base_q + chk_idx_q;
                end
            end else if (live) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            if (spurious) begin
                fail <= 1'b1;
                pass <= 1'b0;
            end

            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        base_q         <= base_addr;
                        num_q          <= num_words;
                        mode_q         <= pattern_sel;
                        wr_idx_q       <= '0;
                        rd_idx_q       <= '0;
                        chk_idx_q      <= '0;
                        out_q          <= '0;
                        tmo_q          <= '0;
                        err_cnt        <= '0;
                        rd_cnt         <= '0;
                        first_err_addr <= '0;
                        fail           <= 1'b0;
                        timeout        <= 1'b0;
                        if (num_words == '0) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end else begin
                            state_q <= StWrite;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            pass    <= 1'b0;
                            wr_en   <= 1'b1;
                            wr_addr <= base_addr;
                            wr_data <= pattern_f(pattern_sel, '0);
                        end
                    end
                end
                StWrite: begin
                    if (wr_en && wr_rdy) begin
                        if (wr_idx_q == num_q - ADDR_W'(1)) begin
                            wr_en   <= 1'b0;
                            state_q <= StRead;
                            rd_en   <= 1'b1;
                            rd_addr <= base_q;
                        end else begin
                            wr_idx_q <= wr_idx_q + ADDR_W'(1);
                            wr_addr  <= base_q + wr_idx_q + ADDR_W'(1);
                            wr_data  <= pattern_f(mode_q, wr_idx_q + ADDR_W'(1));
                        end
                    end
                end
                StRead: begin
                    if (tmo_hit) begin
                        state_q <= StDone;
                        rd_en   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        fail    <= 1'b1;
                        timeout <= 1'b1;
                    end else if (rd_acc && (rd_idx_q == num_q - ADDR_W'(1))) begin
                        rd_en   <= 1'b0;
                        state_q <= StDrain;
                    end else if (rd_acc) begin
                        rd_idx_q <= rd_idx_q + ADDR_W'(1);
                        rd_addr  <= base_q + rd_idx_q + ADDR_W'(1);
                        rd_en    <= (out_d < MaxOut);
                    end else begin
                        rd_en <= (out_d < MaxOut);
                    end
                end
                StDrain: begin
                    if (tmo_hit) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        fail    <= 1'b1;
                        timeout <= 1'b1;
                    end else if (out_q == '0) begin
                        // The last compare landed on the previous edge, so fail is final here.
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= !fail && !spurious;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with an in-order, fixed-latency memory model.
module tb_mem_bist_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start = 1'b0;
    logic [1:0]  pattern_sel = '0;
    logic [23:0] base_addr = '0;
    logic [23:0] num_words = '0;
    logic        wr_rdy = 1'b1;
    logic        wr_en;
    logic [23:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_rdy = 1'b1;
    logic        rd_en;
    logic [23:0] rd_addr;
    logic [31:0] rd_data = '0;
    logic        rd_data_valid = 1'b0;
    logic        busy, done, pass, fail, timeout;
    logic [15:0] err_cnt;
    logic [23:0] first_err_addr;
    logic [23:0] rd_cnt;

    mem_bist_ctrl #(
        .DATA_W  (32),
        .ADDR_W  (24),
        .PATTERN (32'h00FFFFFF),
        .MAX_OUT (8),
        .TIMEOUT (64),
        .ERR_W   (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .pattern_sel    (pattern_sel),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .wr_rdy         (wr_rdy),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_rdy         (rd_rdy),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_data_valid  (rd_data_valid),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail           (fail),
        .timeout        (timeout),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .rd_cnt         (rd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;

    rd_t         rq[$];
    logic [31:0] mem [0:1023];
    int          checks = 0, failures = 0;
    int          cyc = 0, lat = 3, stop_after = -1;
    int          ret_n, out_n, max_out, wr_n, rd_n, bad_wr;
    int          first_wr_cyc, last_wr_cyc, last_vld_cyc;
    bit          stall = 1'b0, inject = 1'b0, corrupt_en = 1'b0;
    logic [23:0] corrupt_addr = '0;
    logic [1:0]  cur_mode = '0;
    logic [23:0] cur_base = '0;

    function automatic logic [31:0] exp_pat(input logic [1:0] m, input logic [23:0] a);
        case (m)
            2'd0:    return 32'h00FFFFFF;
            2'd1:    return {8'h00, a};
            2'd2:    return 32'h1 << a[4:0];
            default: return ~{8'h00, a};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: outputs are sampled and inputs driven on the falling edge.
    task automatic tick();
        rd_t e;
        @(negedge clk);
        cyc++;
        rd_data_valid = 1'b0;
        rd_data       = '0;
        if (inject) begin
            rd_data_valid = 1'b1;
            rd_data       = 32'hDEADBEEF;
            inject        = 1'b0;
        end else if (rq.size() > 0 && rq[0].due <= cyc &&
                     (stop_after < 0 || ret_n < stop_after)) begin
            rd_data       = rq[0].data;
            rd_data_valid = 1'b1;
            void'(rq.pop_front());
            ret_n++;
            out_n--;
            last_vld_cyc = cyc;
        end
        if (stall) begin
            wr_rdy = ($urandom_range(0, 3) != 0);
            rd_rdy = ($urandom_range(0, 3) != 0);
        end else begin
            wr_rdy = 1'b1;
            rd_rdy = 1'b1;
        end
        if (wr_en && wr_rdy) begin
            if (wr_n == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            wr_n++;
            if (wr_data !== exp_pat(cur_mode, wr_addr - cur_base)) bad_wr++;
            mem[wr_addr[9:0]] = wr_data;
        end
        if (rd_en && rd_rdy) begin
            e.data = mem[rd_addr[9:0]] ^ ((corrupt_en && rd_addr == corrupt_addr) ? 32'h1 : 32'h0);
            e.due  = cyc + lat;
            rq.push_back(e);
            rd_n++;
            out_n++;
            if (out_n > max_out) max_out = out_n;
        end
    endtask

    task automatic clear_model();
        rq.delete();
        ret_n = 0; out_n = 0; max_out = 0; wr_n = 0; rd_n = 0; bad_wr = 0;
        first_wr_cyc = 0; last_wr_cyc = 0; last_vld_cyc = 0;
        stop_after = -1; corrupt_en = 1'b0;
    endtask

    // Pulses start, then scrambles the setup inputs, which must be ignored while busy.
    task automatic start_test(input logic [1:0] m, input logic [23:0] b, input logic [23:0] n);
        clear_model();
        cur_mode    = m;
        cur_base    = b;
        pattern_sel = m;
        base_addr   = b;
        num_words   = n;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        pattern_sel = ~m;
        base_addr   = ~b;
        num_words   = 24'd3;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    initial begin
        int n;
        clear_model();
        reset = 1'b1;
        repeat (3) tick();
        check("rst_flags", 64'({wr_en, rd_en, busy, done, pass, fail, timeout}), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_rd_cnt", 64'(rd_cnt), 64'd0);
        check("rst_first_err", 64'(first_err_addr), 64'd0);
        reset = 1'b0;
        tick();

        // Mode 0, 8 words, no stalls, latency 3
        lat = 3; stall = 1'b0;
        start_test(2'd0, 24'h000000, 24'd8);
        check("t1_busy_after_start", 64'(busy), 64'd1);
        check("t1_first_wr_data", 64'(wr_data), 64'h00FFFFFF);
        wait_done("t1_done", 300);
        check("t1_wr_count", 64'(wr_n), 64'd8);
        check("t1_wr_back_to_back", 64'(last_wr_cyc - first_wr_cyc), 64'd7);
        check("t1_wr_data_bad", 64'(bad_wr), 64'd0);
        check("t1_pass_fail", 64'({pass, fail, busy}), 64'b100);
        check("t1_err_cnt", 64'(err_cnt), 64'd0);
        check("t1_rd_cnt", 64'(rd_cnt), 64'd8);

        // Mode 1, base 0x100, word 0x105 corrupted on readback
        start_test(2'd1, 24'h000100, 24'd16);
        corrupt_en = 1'b1; corrupt_addr = 24'h000105;
        wait_done("t2_done", 300);
        check("t2_wr_data_bad", 64'(bad_wr), 64'd0);
        check("t2_pass_fail", 64'({pass, fail}), 64'b01);
        check("t2_err_cnt", 64'(err_cnt), 64'd1);
        check("t2_first_err", 64'(first_err_addr), 64'h105);
        check("t2_rd_cnt", 64'(rd_cnt), 64'd16);

        // Mode 2, 40 words, random stalls, latency 20
        lat = 20; stall = 1'b1;
        start_test(2'd2, 24'h000000, 24'd40);
        wait_done("t3_done", 3000);
        stall = 1'b0;
        check("t3_max_out_le8", 64'(max_out <= 8), 64'd1);
        check("t3_walk_a33", 64'(mem[33]), 64'h2);
        check("t3_wr_data_bad", 64'(bad_wr), 64'd0);
        check("t3_pass", 64'({pass, fail}), 64'b10);
        check("t3_rd_cnt", 64'(rd_cnt), 64'd40);

        // Memory stops after 5 of 10 returns; TIMEOUT is 64
        lat = 3;
        start_test(2'd0, 24'h000000, 24'd10);
        stop_after = 5;
        wait_done("t4_done", 500);
        check("t4_flags", 64'({timeout, fail, pass}), 64'b110);
        check("t4_rd_cnt", 64'(rd_cnt), 64'd5);
        // valid driven at negedge v is sampled on the following edge; done seen one negedge later
        check("t4_tmo_latency", 64'(cyc - last_vld_cyc - 1), 64'd64);

        // num_words = 0: immediate pass, no traffic
        start_test(2'd0, 24'h000010, 24'd0);
        check("t5_done_pass", 64'({done, pass, busy, timeout}), 64'b1100);
        repeat (5) tick();
        check("t5_no_traffic", 64'(wr_n + rd_n), 64'd0);
        check("t5_done_held", 64'(done), 64'd1);

        // Spurious return in IDLE
        reset = 1'b1;
        tick();
        reset = 1'b0;
        inject = 1'b1;
        tick();
        tick();
        check("t5_spurious_fail", 64'({fail, pass, done}), 64'b100);
        check("t5_spurious_counts", 64'({err_cnt, rd_cnt}), 64'd0);

        // Reset mid-READ, then a clean mode 3 run
        lat = 20;
        start_test(2'd3, 24'h000020, 24'd12);
        n = 0;
        while (ret_n < 2 && n < 300) begin
            tick();
            n++;
        end
        check("t6_in_read", 64'({busy, ret_n >= 2}), 64'b11);
        #2;
        reset = 1'b1;
        rq.delete();
        #1;
        check("t6_rst_flags", 64'({wr_en, rd_en, busy, done, pass, fail, timeout}), 64'd0);
        check("t6_rst_data", 64'({wr_data, rd_cnt}), 64'd0);
        check("t6_rst_addr", 64'({wr_addr, rd_addr}), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        start_test(2'd3, 24'h000020, 24'd12);
        wait_done("t6_done", 500);
        check("t6_pass", 64'({pass, fail, timeout}), 64'b100);
        check("t6_rd_cnt", 64'(rd_cnt), 64'd12);
        check("t6_inv_a5", 64'(mem[10'h025]), 64'hFFFFFFFA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
Parametrised memory built-in self-test controller for the frame-buffer memory ports.
- Writes a selectable, address-derived data pattern over a programmable address range, then reads the range back.
- Compares returned data in order and reports pass/fail, error count and first failing address.
- Sits between a debug source/probe interface and one port of the multi-port RAM interface.
- Generalises the existing single-constant, fixed-address check to any width, range and pattern, with outstanding-read tracking and a timeout.

Parameters:
DATA_W, 32, data width of the memory port
ADDR_W, 24, address width of the memory port
PATTERN, 32'h00FFFFFF, constant used by pattern mode 0 (truncated/zero-extended to DATA_W)
MAX_OUT, 8, maximum outstanding (issued, not yet returned) reads; power of two, at least 2
TIMEOUT, 1024, cycles without rd_data_valid while reads are outstanding before timeout is declared
ERR_W, 16, width of the saturating error counter

Ports:
clk  in  1  single system clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a test when in IDLE or DONE
pattern_sel  in  2  0 = PATTERN, 1 = address, 2 = walking one, 3 = inverted address
base_addr  in  ADDR_W  first address tested
num_words  in  ADDR_W  number of words tested
wr_rdy  in  1  memory can accept a write this cycle
wr_en  out  1  write request
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
rd_rdy  in  1  memory can accept a read this cycle
rd_en  out  1  read request
rd_addr  out  ADDR_W  read address
rd_data  in  DATA_W  returned read data
rd_data_valid  in  1  one-cycle strobe per returned word, returned in request order
busy  out  1  test in progress
done  out  1  test finished; held until the next start
pass  out  1  done with zero errors and no timeout
fail  out  1  any error, spurious return or timeout; sticky
timeout  out  1  timeout occurred; sticky
err_cnt  out  ERR_W  mismatch count; saturates at all-ones
first_err_addr  out  ADDR_W  address of the first mismatch
rd_cnt  out  ADDR_W  words returned and checked

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset asserted mid-test aborts immediately and discards outstanding reads.
- Address and size are latched on start; pattern_sel, base_addr and num_words are ignored while busy. start is ignored while busy.
- Pattern f(a), where a = address relative to base_addr:
  - mode 0: PATTERN
  - mode 1: a, zero-extended/truncated to DATA_W
  - mode 2: 1 << (a mod DATA_W)
  - mode 3: ~a
- FSM IDLE -> WRITE -> READ -> DRAIN -> DONE. DONE -> WRITE on start.
- On start, clear err_cnt, rd_cnt, first_err_addr, fail, timeout, pass and done. Set busy in the cycle after start.
- If num_words = 0 on start: go straight to DONE. pass = 1 one cycle after start; no memory traffic.
- Write handshake:
  - A transfer occurs on wr_en && wr_rdy.
  - wr_en, wr_addr and wr_data hold stable until accepted.
  - Next word is presented the cycle after acceptance; this supports 1 word/cycle while wr_rdy stays high.
  - After the last accepted write: WRITE -> READ.
- Read handshake:
  - A transfer occurs on rd_en && rd_rdy.
  - rd_en is asserted only while the outstanding count < MAX_OUT.
  - Outstanding count +1 on acceptance, -1 on rd_data_valid; both in one cycle leaves it unchanged.
  - After the last read is accepted: READ -> DRAIN.
- Check path:
  - A separate check-address counter starts at 0 and advances on each rd_data_valid.
  - Compare rd_data with f(check address), registered one cycle.
  - A mismatch increments err_cnt (saturating) and sets fail.
  - The first mismatch captures base_addr + check address into first_err_addr.
  - rd_cnt increments on every valid.
- DRAIN -> DONE when the outstanding count reaches 0 and the final compare has been registered.
  - done = 1.
  - pass = !fail one cycle after the last valid.
  - busy = 0.
- Spurious return: rd_data_valid in IDLE, WRITE or DONE, or with 0 outstanding, sets fail. No count change.
- Timeout: a counter runs while outstanding > 0 and clears on each valid. Reaching TIMEOUT sets timeout and fail and forces DONE.
- Address arithmetic wraps modulo 2^ADDR_W.

Test Plan:
- Mode 0, base 0, num_words 8, wr_rdy and rd_rdy tied 1, data echoed with 3-cycle latency -> 8 writes of 32'h00FFFFFF on consecutive cycles; pass = 1, err_cnt = 0, rd_cnt = 8.
- Mode 1, base 0x100, num_words 16, memory model corrupts word at 0x105 -> fail = 1, err_cnt = 1, first_err_addr = 0x105, done = 1, pass = 0.
- Mode 2, DATA_W = 32, num_words 40, random wr_rdy/rd_rdy stalls, 20-cycle read latency -> outstanding never exceeds 8; data at a = 33 is 32'h2; pass = 1.
- Memory stops returning after 5 of 10 reads, TIMEOUT = 64 -> timeout = 1, fail = 1, rd_cnt = 5, done 64 cycles after the 5th valid.
- num_words 0 -> done and pass one cycle after start, no wr_en/rd_en. rd_data_valid strobe in IDLE -> fail = 1.
- Reset asserted mid-READ -> all outputs 0 immediately. A new start then runs a clean test to pass.
